zled_dimmer: RTL and testbench



---
 rtl/zled_pkg.sv | 19 +
 rtl/zled_pwm_core.sv | 58 +++++
 rtl/zled_dimmer.sv | 119 +++++++++++
 tb/tb_zled_dimmer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zled_pkg.sv
// Shared types and default parameters for the switch-driven LED dimmer.
// The breathe mode is compiled in by ZLED_DIMMER_BREATHE_EN in the top level.
package zled_pkg;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_STEP     = 16;
    localparam int DEF_PRESCALE = 4;

    typedef enum logic {
        ST_MANUAL  = 1'b0,
        ST_BREATHE = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/zled_pwm_core.sv
// Prescaled PWM generator: duty reloads only at period start, compare is registered (1 cycle).
// Never stalls; oPeriodStart is a one-cycle strobe on the edge where the counter wraps.
module zled_pwm_core
    import zled_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [PWM_BITS-1:0] iLevel,
    output logic                oLed,
    output logic                oPeriodStart
);

    localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = LVL_MAX - PWM_BITS'(1);

    logic [PRE_W-1:0]    pre_q,  pre_d;
    logic [PWM_BITS-1:0] cnt_q,  cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q,  led_d;
    logic                tick;
    logic                period_start;

    always_comb begin
        tick         = (pre_q == PRE_LAST);
        pre_d        = tick ? '0 : pre_q + PRE_W'(1);
        period_start = tick && (cnt_q == CNT_LAST);
        cnt_d        = cnt_q;
        if (tick) begin
            cnt_d = period_start ? '0 : cnt_q + PWM_BITS'(1);
        end
        // Counter never reaches MAX, so duty MAX keeps the LED on for the whole period.
        duty_d = period_start ? iLevel : duty_q;
        led_d  = (cnt_q < duty_q);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign oLed         = led_q;
    assign oPeriodStart = period_start;

endmodule

// File: rtl/zled_dimmer.sv
// Switch-driven LED dimmer: saturating level from up/down pulses, PWM drive; level updates 1 cycle after a pulse.
// Optional autonomous breathing ramp enabled by defining ZLED_DIMMER_BREATHE_EN.
module zled_dimmer
    import zled_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP     = DEF_STEP,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iSwUp,
    input  logic                iSwDown,
    input  logic                iMode,
    output logic                oLed,
    output logic [PWM_BITS-1:0] oLevel,
    output logic                oBreathing
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS:0]   MAX_W   = {1'b0, LVL_MAX};
    localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS + 1)'(STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] manual_level;
    logic [PWM_BITS:0]   level_up_w;
    logic [PWM_BITS:0]   level_dn_w;
    logic                period_start;

    // One extra bit catches overflow on the way up and borrow on the way down.
    always_comb begin
        level_up_w   = {1'b0, level_q} + STEP_W;
        level_dn_w   = {1'b0, level_q} - STEP_W;
        manual_level = level_q;
        if (iSwUp && !iSwDown) begin
            manual_level = (level_up_w > MAX_W) ? LVL_MAX : level_up_w[PWM_BITS-1:0];
        end else if (iSwDown && !iSwUp) begin
            manual_level = level_dn_w[PWM_BITS] ? '0 : level_dn_w[PWM_BITS-1:0];
        end
    end

`ifdef ZLED_DIMMER_BREATHE_EN
    state_e state_q, state_d;
    dir_e   dir_q,   dir_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        level_d = level_q;
        case (state_q)
            ST_MANUAL: begin
                if (iMode) begin
                    state_d = ST_BREATHE;
                    dir_d   = (level_q == LVL_MAX) ? DIR_DOWN : DIR_UP;
                end else begin
                    level_d = manual_level;
                end
            end
            ST_BREATHE: begin
                if (iMode) begin
                    state_d = ST_MANUAL;
                end else if (period_start) begin
                    // Direction turns on the same update that lands on a bound.
                    if (dir_q == DIR_UP) begin
                        level_d = level_q + PWM_BITS'(1);
                        if (level_d == LVL_MAX) dir_d = DIR_DOWN;
                    end else begin
                        level_d = level_q - PWM_BITS'(1);
                        if (level_d == '0) dir_d = DIR_UP;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_MANUAL;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    assign oBreathing = (state_q == ST_BREATHE);
`else
    logic unused_mode;

    always_comb begin
        level_d = manual_level;
    end

    assign unused_mode = &{1'b0, iMode, period_start};
    assign oBreathing  = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    zled_pwm_core #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .iClk         (iClk),
        .iRst         (iRst),
        .iLevel       (level_q),
        .oLed         (oLed),
        .oPeriodStart (period_start)
    );

    assign oLevel = level_q;

endmodule

// File: tb/tb_zled_dimmer.sv
// Directed bench for zled_dimmer with default parameters (8-bit, STEP 16, PRESCALE 4, period 1020 cycles).
module tb_zled_dimmer;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iSwUp = 1'b0;
    logic       iSwDown = 1'b0;
    logic       iMode = 1'b0;
    logic       oLed;
    logic [7:0] oLevel;
    logic       oBreathing;

    int nvec = 0;
    int nerr = 0;

    zled_dimmer #(
        .PWM_BITS (8),
        .STEP     (16),
        .PRESCALE (4)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iSwUp      (iSwUp),
        .iSwDown    (iSwDown),
        .iMode      (iMode),
        .oLed       (oLed),
        .oLevel     (oLevel),
        .oBreathing (oBreathing)
    );

    always #5 iClk = ~iClk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        iSwUp = 1'b0;
        iSwDown = 1'b0;
        iMode = 1'b0;
        step(2);
        iRst = 1'b0;
    endtask

    task automatic pulse_up();
        iSwUp = 1'b1;
        step(1);
        iSwUp = 1'b0;
    endtask

    task automatic pulse_down();
        iSwDown = 1'b1;
        step(1);
        iSwDown = 1'b0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (oLed) hi++;
        end
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        prev = oLed;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (!prev && oLed) begin
                ok = 1'b1;
                break;
            end
            prev = oLed;
        end
    endtask

    // Length of the high run that starts at the current sample; optionally adds
    // four up pulses about 100 PWM ticks into the period.
    task automatic measure_run(input bit inject, output int n);
        n = 1;
        for (int i = 0; i < 1200; i++) begin
            iSwUp = inject && (i == 400 || i == 402 || i == 404 || i == 406);
            step(1);
            if (!oLed) break;
            n++;
        end
        iSwUp = 1'b0;
    endtask

    task automatic wait_level_change(output bit ok);
        logic [7:0] old;
        old = oLevel;
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step(1);
            if (oLevel !== old) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int hi;
        do_reset();
        nvec++;
        if (oLevel !== 8'd0) begin nerr++; $display("FAIL reset_level got %0d want 0", oLevel); end
        nvec++;
        if (oLed !== 1'b0) begin nerr++; $display("FAIL reset_led got %b want 0", oLed); end
        nvec++;
        if (oBreathing !== 1'b0) begin nerr++; $display("FAIL reset_breathing got %b want 0", oBreathing); end
        count_high(1100, hi);
        nvec++;
        if (hi !== 0) begin nerr++; $display("FAIL reset_dark high=%0d want 0", hi); end
    endtask

    task automatic test_up8();
        int hi;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            pulse_up();
            nvec++;
            if (oLevel !== 8'(16 * k)) begin
                nerr++; $display("FAIL up8_level pulse %0d got %0d want %0d", k, oLevel, 16 * k);
            end
        end
        step(1100);
        count_high(1020, hi);
        nvec++;
        if (hi !== 512) begin nerr++; $display("FAIL up8_duty high=%0d want 512", hi); end
    endtask

    task automatic test_saturate();
        int hi;
        do_reset();
        repeat (15) pulse_up();
        nvec++;
        if (oLevel !== 8'd240) begin nerr++; $display("FAIL sat_15 got %0d want 240", oLevel); end
        pulse_up();
        nvec++;
        if (oLevel !== 8'd255) begin nerr++; $display("FAIL sat_16 got %0d want 255", oLevel); end
        pulse_up();
        nvec++;
        if (oLevel !== 8'd255) begin nerr++; $display("FAIL sat_17 got %0d want 255", oLevel); end
        step(1100);
        count_high(1020, hi);
        nvec++;
        if (hi !== 1020) begin nerr++; $display("FAIL sat_duty high=%0d want 1020", hi); end
    endtask

    task automatic test_both_and_floor();
        int hi;
        logic [7:0] exp_lvl [5];
        exp_lvl = '{8'd48, 8'd32, 8'd16, 8'd0, 8'd0};
        do_reset();
        repeat (4) pulse_up();
        nvec++;
        if (oLevel !== 8'd64) begin nerr++; $display("FAIL both_pre got %0d want 64", oLevel); end
        iSwUp = 1'b1;
        iSwDown = 1'b1;
        step(1);
        iSwUp = 1'b0;
        iSwDown = 1'b0;
        nvec++;
        if (oLevel !== 8'd64) begin nerr++; $display("FAIL both_same_cycle got %0d want 64", oLevel); end
        for (int k = 0; k < 5; k++) begin
            pulse_down();
            nvec++;
            if (oLevel !== exp_lvl[k]) begin
                nerr++; $display("FAIL down_level pulse %0d got %0d want %0d", k + 1, oLevel, exp_lvl[k]);
            end
        end
        step(1100);
        count_high(1020, hi);
        nvec++;
        if (hi !== 0) begin nerr++; $display("FAIL floor_duty high=%0d want 0", hi); end
    endtask

    task automatic test_mid_period();
        bit ok;
        int run;
        do_reset();
        repeat (8) pulse_up();
        wait_rise(ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL mid_rise1 timeout got 0 want 1"); end
        measure_run(1'b1, run);
        nvec++;
        if (run !== 512) begin nerr++; $display("FAIL mid_run_old got %0d want 512", run); end
        nvec++;
        if (oLevel !== 8'd192) begin nerr++; $display("FAIL mid_level got %0d want 192", oLevel); end
        wait_rise(ok);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL mid_rise2 timeout got 0 want 1"); end
        measure_run(1'b0, run);
        nvec++;
        if (run !== 768) begin nerr++; $display("FAIL mid_run_new got %0d want 768", run); end
    endtask

`ifdef ZLED_DIMMER_BREATHE_EN
    task automatic test_breathe();
        bit ok;
        int exp_l;
        do_reset();
        repeat (15) pulse_up();
        iMode = 1'b1;
        step(1);
        iMode = 1'b0;
        nvec++;
        if (oBreathing !== 1'b1) begin nerr++; $display("FAIL br_enter got %b want 1", oBreathing); end
        nvec++;
        if (oLevel !== 8'd240) begin nerr++; $display("FAIL br_enter_level got %0d want 240", oLevel); end
        for (int k = 1; k <= 17; k++) begin
            exp_l = (k <= 15) ? 240 + k : 255 - (k - 15);
            wait_level_change(ok);
            nvec++;
            if (!ok || oLevel !== 8'(exp_l)) begin
                nerr++; $display("FAIL br_ramp step %0d got %0d (ok=%0d) want %0d", k, oLevel, ok, exp_l);
            end
        end
        pulse_up();
        nvec++;
        if (oLevel !== 8'd253) begin nerr++; $display("FAIL br_sw_ignored got %0d want 253", oLevel); end
        iMode = 1'b1;
        iSwDown = 1'b1;
        step(1);
        iMode = 1'b0;
        iSwDown = 1'b0;
        nvec++;
        if (oBreathing !== 1'b0 || oLevel !== 8'd253) begin
            nerr++; $display("FAIL br_exit got brth=%b lvl=%0d want brth=0 lvl=253", oBreathing, oLevel);
        end
        step(1100);
        nvec++;
        if (oLevel !== 8'd253) begin nerr++; $display("FAIL br_frozen got %0d want 253", oLevel); end
        pulse_up();
        nvec++;
        if (oLevel !== 8'd255) begin nerr++; $display("FAIL br_clamp got %0d want 255", oLevel); end
        iMode = 1'b1;
        step(1);
        iMode = 1'b0;
        wait_level_change(ok);
        nvec++;
        if (!ok || oLevel !== 8'd254) begin
            nerr++; $display("FAIL br_enter_max got %0d (ok=%0d) want 254", oLevel, ok);
        end
        step(300);
        iRst = 1'b1;
        step(1);
        nvec++;
        if (oLevel !== 8'd0 || oLed !== 1'b0 || oBreathing !== 1'b0) begin
            nerr++; $display("FAIL br_reset got lvl=%0d led=%b brth=%b want 0 0 0", oLevel, oLed, oBreathing);
        end
        iRst = 1'b0;
    endtask
`else
    task automatic test_mode_ignored();
        do_reset();
        repeat (2) pulse_up();
        iMode = 1'b1;
        iSwUp = 1'b1;
        step(1);
        iMode = 1'b0;
        iSwUp = 1'b0;
        nvec++;
        if (oBreathing !== 1'b0) begin nerr++; $display("FAIL mode_ign_brth got %b want 0", oBreathing); end
        nvec++;
        if (oLevel !== 8'd48) begin nerr++; $display("FAIL mode_ign_level got %0d want 48", oLevel); end
    endtask
`endif

    initial begin
        test_reset();
        test_up8();
        test_saturate();
        test_both_and_floor();
        test_mid_period();
`ifdef ZLED_DIMMER_BREATHE_EN
        test_breathe();
`else
        test_mode_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
